// File: rtl/rv32c_fetch_align.sv
// Instruction-fetch aligner: buffers ROM words as halfwords and presents one
// whole RV32C instruction (16- or 32-bit, possibly word-straddling) per handshake.
module rv32c_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    output logic              oROM_RD,
    output logic [ADDR_W-1:0] oROM_ADDR,
    input  logic [31:0]       iROM_DATA,
    input  logic              iREDIRECT,
    input  logic [31:0]       iREDIRECT_PC,
    output logic              oVALID,
    input  logic              iREADY,
    output logic [31:0]       oIR,
    output logic              oIS_C,
    output logic [31:0]       oPC
);

    logic [15:0]       hw_q [4];
    logic [15:0]       hw_d [4];
    logic [2:0]        count_q, count_d;
    logic              inflight_q, inflight_d;
    logic              skip_q, skip_d;
    logic [31:0]       pc_q, pc_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;

    logic [15:0] view [4];
    logic [2:0]  view_cnt;
    logic [1:0]  wr_idx;
    logic        flush;
    logic        head_c;
    logic        valid;
    logic        fire;
    logic [1:0]  pop;
    logic [3:0]  need;
    logic        issue;

    // The returning word is merged into a combinational view of the queue so
    // it can be presented in its arrival cycle; the issue rule keeps it <= 4.
    always_comb begin
        flush    = iRST | iREDIRECT;
        view     = hw_q;
        view_cnt = count_q;
        wr_idx   = count_q[1:0];
        if (inflight_q && !flush) begin
            if (skip_q) begin
                view[wr_idx] = iROM_DATA[31:16];
                view_cnt     = count_q + 3'd1;
            end else begin
                view[wr_idx]         = iROM_DATA[15:0];
                view[wr_idx + 2'd1]  = iROM_DATA[31:16];
                view_cnt             = count_q + 3'd2;
            end
        end

        head_c = (view[0][1:0] != 2'b11);
        valid  = !flush && (((view_cnt != 3'd0) && head_c) || (view_cnt >= 3'd2));
        fire   = valid && iREADY;
        if (!fire)
            pop = 2'd0;
        else if (head_c)
            pop = 2'd1;
        else
            pop = 2'd2;

        need  = {1'b0, count_q} + {2'b00, inflight_q, 1'b0};
        issue = !flush && (need <= (4'd2 + {2'b00, pop}));
    end

    always_comb begin
        hw_d = view;
        case (pop)
            2'd1: begin
                hw_d[0] = view[1];
                hw_d[1] = view[2];
                hw_d[2] = view[3];
            end
            2'd2: begin
                hw_d[0] = view[2];
                hw_d[1] = view[3];
            end
            default: ;
        endcase

        count_d    = view_cnt - {1'b0, pop};
        inflight_d = issue;
        skip_d     = skip_q && !inflight_q;
        faddr_d    = issue ? faddr_q + ADDR_W'(1) : faddr_q;
        pc_d       = fire ? pc_q + (head_c ? 32'd2 : 32'd4) : pc_q;

        // A redirect discards the queue and any word arriving this cycle.
        if (iREDIRECT) begin
            count_d    = 3'd0;
            inflight_d = 1'b0;
            skip_d     = iREDIRECT_PC[1];
            faddr_d    = iREDIRECT_PC[ADDR_W+1:2];
            pc_d       = iREDIRECT_PC & ~32'h1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < 4; i++)
                hw_q[i] <= 16'h0;
            count_q    <= 3'd0;
            inflight_q <= 1'b0;
            skip_q     <= RESET_PC[1];
            faddr_q    <= RESET_PC[ADDR_W+1:2];
            pc_q       <= RESET_PC;
        end else begin
            hw_q       <= hw_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            skip_q     <= skip_d;
            faddr_q    <= faddr_d;
            pc_q       <= pc_d;
        end
    end

    always_comb begin
        oROM_RD   = issue;
        oROM_ADDR = faddr_q;
        oVALID    = valid;
        oIS_C     = valid && head_c;
        oPC       = pc_q;
        oIR       = 32'h0;
        if (valid)
            oIR = head_c ? {16'h0, view[0]} : {view[1], view[0]};
    end

endmodule

// File: tb/tb_rv32c_fetch_align.sv
// Scoreboard bench for rv32c_fetch_align: a ROM model feeds the DUT and a
// high-level instruction-stream model predicts every presented instruction.
module tb_rv32c_fetch_align;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        oROM_RD;
    logic [7:0]  oROM_ADDR;
    logic [31:0] iROM_DATA = 32'h0;
    logic        iREDIRECT = 1'b0;
    logic [31:0] iREDIRECT_PC = 32'h0;
    logic        oVALID;
    logic        iREADY = 1'b1;
    logic [31:0] oIR;
    logic        oIS_C;
    logic [31:0] oPC;

    rv32c_fetch_align #(.RESET_PC(TB_RESET_PC), .ADDR_W(8)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .oROM_RD     (oROM_RD),
        .oROM_ADDR   (oROM_ADDR),
        .iROM_DATA   (iROM_DATA),
        .iREDIRECT   (iREDIRECT),
        .iREDIRECT_PC(iREDIRECT_PC),
        .oVALID      (oVALID),
        .iREADY      (iREADY),
        .oIR         (oIR),
        .oIS_C       (oIS_C),
        .oPC         (oPC)
    );

    always #5 iCLK = ~iCLK;

    logic [31:0] rom [256];

    // ROM answers exactly one cycle after a read strobe
    always @(posedge iCLK) begin
        if (oROM_RD)
            iROM_DATA <= rom[oROM_ADDR];
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        isc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_lat = 2;

    int       since = 0;
    bit       seen_first = 1'b0;
    bit       after_rst = 1'b1;
    logic [7:0] exp_faddr = 8'h00;

    function automatic logic [15:0] halfword(input logic [31:0] a);
        logic [31:0] w;
        w = rom[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the program from a start PC and queue the instructions decode should see
    task automatic startStream(input logic [31:0] start);
        logic [31:0] a;
        logic [15:0] hw;
        exp_t e;
        exp_q.delete();
        a = start & ~32'h1;
        hw = halfword(a);
        exp_lat = (a[1] && hw[1:0] == 2'b11) ? 3 : 2;
        for (int i = 0; i < 64; i++) begin
            hw = halfword(a);
            e.pc = a;
            if (hw[1:0] != 2'b11) begin
                e.ir  = {16'h0, hw};
                e.isc = 1'b1;
                a     = a + 32'd2;
            end else begin
                e.ir  = {halfword(a + 32'd2), hw};
                e.isc = 1'b0;
                a     = a + 32'd4;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit redir, input logic [31:0] pc, input bit rdy);
        @(posedge iCLK);
        #1;
        iRST         = rst;
        iREDIRECT    = redir;
        iREDIRECT_PC = pc;
        iREADY       = rdy;
        if (rst)
            startStream(TB_RESET_PC);
        else if (redir)
            startStream(pc);
    endtask

    task automatic runCycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
                1: applyStimulus(1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
                default: applyStimulus(1'b0, 1'b0, 32'h0, $urandom_range(0, 3) == 0);
            endcase
        end
    endtask

    // Monitor: protocol, latency, throughput and scoreboard checks each cycle
    always @(negedge iCLK) begin
        exp_t e;
        if (iRST || iREDIRECT) begin
            checkOutput("flush_valid", 32'(oVALID), 32'h0);
            checkOutput("flush_rd", 32'(oROM_RD), 32'h0);
            if (iRST) begin
                checkOutput("rst_ir", oIR, 32'h0);
                checkOutput("rst_isc", 32'(oIS_C), 32'h0);
            end
            since      = 0;
            seen_first = 1'b0;
            after_rst  = iRST;
            exp_faddr  = iRST ? TB_RESET_PC[9:2] : iREDIRECT_PC[9:2];
        end else begin
            since++;
            if (oROM_RD) begin
                checkOutput("rom_addr", 32'(oROM_ADDR), 32'(exp_faddr));
                exp_faddr = exp_faddr + 8'd1;
            end
            if (since == 1) begin
                checkOutput("fetch_after_flush", 32'(oROM_RD), 32'h1);
                if (after_rst) begin
                    checkOutput("post_rst_ir", oIR, 32'h0);
                    checkOutput("post_rst_isc", 32'(oIS_C), 32'h0);
                end
            end
            if (!seen_first) begin
                if (since < exp_lat) begin
                    checkOutput("lat_quiet", 32'(oVALID), 32'h0);
                end else begin
                    checkOutput("latency", 32'(oVALID), 32'h1);
                    seen_first = 1'b1;
                end
            end else begin
                checkOutput("sustain", 32'(oVALID), 32'h1);
            end
            if (oVALID) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_empty", 32'h1, 32'h0);
                end else begin
                    e = exp_q[0];
                    checkOutput("ir", oIR, e.ir);
                    checkOutput("pc", oPC, e.pc);
                    checkOutput("is_c", 32'(oIS_C), 32'(e.isc));
                    if (iREADY)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        int          r;
        for (int i = 0; i < 256; i++)
            rom[i] = $urandom;
        rom[8'h00] = 32'h0050_0093;
        rom[8'h01] = 32'h00A0_0113;
        rom[8'h04] = 32'h4585_0001;
        rom[8'h10] = 32'hC22A_C02E;
        rom[8'h20] = 32'h0093_4505;
        rom[8'h21] = 32'h0000_0050;
        rom[8'hFF] = 32'h00A0_0113;
        startStream(TB_RESET_PC);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        runCycles(6, 0);

        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        runCycles(6, 0);

        applyStimulus(1'b0, 1'b1, 32'h0000_0080, 1'b1);
        runCycles(6, 0);

        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        runCycles(3, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge iCLK);
        checkOutput("stall_rd", 32'(oROM_RD), 32'h0);
        runCycles(8, 0);

        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        runCycles(1, 0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0012, 1'b1);
        runCycles(6, 0);

        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1);
        runCycles(6, 0);

        applyStimulus(1'b0, 1'b1, 32'h0000_03FC, 1'b1);
        runCycles(8, 0);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        runCycles(8, 0);

        for (int s = 0; s < 40; s++) begin
            r   = $urandom_range(0, 9);
            rpc = $urandom & 32'hFFFF_FFFE;
            if (r == 0)
                applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            else
                applyStimulus(1'b0, 1'b1, rpc, 1'b1);
            runCycles($urandom_range(5, 25), $urandom_range(0, 2));
        end

        runCycles(2, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
